udp_payload_streamer: RTL and testbench

- Transmit-side stage of the controller; sits between the simulation/execution output RAM and the UDP/MAC stack.
- On a start pulse it latches the packet fields and presents one UDP header on the stack's header handshake.
- It then reads N 16-bit words from RAM and streams them as 2N payload bytes on an 8-bit AXI-stream, big-endian, with tlast on the final byte.

---
 rtl/udp_payload_streamer.sv | 184 ++++++++++++++++++
 tb/tb_udp_payload_streamer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_payload_streamer.sv
// Transmit stage: latches one UDP header, then streams N RAM words as 2N big-endian
// payload bytes on an 8-bit AXI-stream, with tlast on the final byte.
module udp_payload_streamer #(
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  out_len,
  input  logic [15:0]           udp_dest_port,
  input  logic [15:0]           udp_source_port,
  input  logic [31:0]           ip_dest_ip,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  ram_rd,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [15:0]           ram_q,
  output logic                  m_udp_hdr_valid,
  input  logic                  m_udp_hdr_ready,
  output logic [31:0]           m_udp_ip_dest_ip,
  output logic [15:0]           m_udp_source_port,
  output logic [15:0]           m_udp_dest_port,
  output logic [15:0]           m_udp_length,
  output logic [7:0]            m_udp_payload_axis_tdata,
  output logic                  m_udp_payload_axis_tvalid,
  input  logic                  m_udp_payload_axis_tready,
  output logic                  m_udp_payload_axis_tlast,
  output logic                  m_udp_payload_axis_tuser
);
  // Handshakes: a transfer happens on a rising clk edge where valid && ready; once
  // valid is high the source holds its data until that edge, and valid never looks at ready.
  typedef enum logic [1:0] {IDLE, HDR, STREAM, DONE} state_t;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(2 ** ADDR_WIDTH);

  state_t                state;
  logic [LEN_WIDTH-1:0]  len, rd_cnt, out_cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  pend, phase, cur_valid, nxt_valid;
  logic [15:0]           cur_word, nxt_word;
  logic                  busy_q, done_q, err_q, hdr_valid_q;
  logic [31:0]           ip_q;
  logic [15:0]           sport_q, dport_q, length_q;

  logic        len_ok, active, rd_en, rd_last, head_valid, tvalid_i, fire, pop;
  logic        last_word, tlast_i;
  logic [1:0]  owned;
  logic [15:0] head_word;
  logic [7:0]  head_byte;
  logic        cur_valid_n, nxt_valid_n;
  logic [15:0] cur_word_n, nxt_word_n;

  assign len_ok     = (out_len != '0) && (out_len <= MAX_LEN);
  assign active     = (state == HDR) || (state == STREAM);
  // Words owned = output word + prefetch word + read in flight; never exceed the two slots.
  assign owned      = 2'(cur_valid) + 2'(nxt_valid) + 2'(pend);
  assign rd_en      = active && (rd_cnt != len) && (owned < 2'd2);
  assign rd_last    = (rd_cnt == len - LEN_WIDTH'(1));
  assign head_valid = cur_valid || pend;
  assign head_word  = cur_valid ? cur_word : ram_q;
  assign head_byte  = phase ? head_word[7:0] : head_word[15:8];
  assign tvalid_i   = (state == STREAM) && head_valid;
  assign fire       = tvalid_i && m_udp_payload_axis_tready;
  assign pop        = fire && phase;
  assign last_word  = (out_cnt == len - LEN_WIDTH'(1));
  assign tlast_i    = tvalid_i && phase && last_word;

  // Word order is cur, nxt, then the word arriving from RAM; a popped head shifts them up.
  always_comb begin
    cur_valid_n = cur_valid;
    cur_word_n  = cur_word;
    nxt_valid_n = nxt_valid;
    nxt_word_n  = nxt_word;
    if (!cur_valid) begin
      cur_valid_n = pend;
      cur_word_n  = ram_q;
      nxt_valid_n = 1'b0;
    end else if (pop) begin
      if (nxt_valid) begin
        cur_word_n  = nxt_word;
        nxt_valid_n = pend;
        nxt_word_n  = ram_q;
      end else begin
        cur_valid_n = pend;
        cur_word_n  = ram_q;
      end
    end else if (!nxt_valid) begin
      nxt_valid_n = pend;
      nxt_word_n  = ram_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      len         <= '0;
      rd_cnt      <= '0;
      out_cnt     <= '0;
      addr        <= '0;
      pend        <= 1'b0;
      phase       <= 1'b0;
      cur_valid   <= 1'b0;
      nxt_valid   <= 1'b0;
      cur_word    <= '0;
      nxt_word    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      hdr_valid_q <= 1'b0;
      ip_q        <= '0;
      sport_q     <= '0;
      dport_q     <= '0;
      length_q    <= '0;
    end else begin
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      pend      <= rd_en;
      cur_valid <= cur_valid_n;
      cur_word  <= cur_word_n;
      nxt_valid <= nxt_valid_n;
      nxt_word  <= nxt_word_n;
      if (fire) phase <= ~phase;
      if (pop) out_cnt <= out_cnt + LEN_WIDTH'(1);
      if (rd_en) begin
        rd_cnt <= rd_cnt + LEN_WIDTH'(1);
        if (!rd_last) addr <= addr + ADDR_WIDTH'(1);
      end
      case (state)
        IDLE: begin
          if (start && len_ok) begin
            state       <= HDR;
            len         <= out_len;
            ip_q        <= ip_dest_ip;
            sport_q     <= udp_source_port;
            dport_q     <= udp_dest_port;
            length_q    <= 16'd8 + (16'(out_len) << 1);
            busy_q      <= 1'b1;
            hdr_valid_q <= 1'b1;
            rd_cnt      <= '0;
            out_cnt     <= '0;
            addr        <= '0;
            pend        <= 1'b0;
            phase       <= 1'b0;
            cur_valid   <= 1'b0;
            nxt_valid   <= 1'b0;
          end else if (start) begin
            err_q <= 1'b1;
          end
        end
        HDR: begin
          if (m_udp_hdr_ready) begin
            hdr_valid_q <= 1'b0;
            state       <= STREAM;
          end
        end
        STREAM: begin
          if (fire && tlast_i) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy                      = busy_q;
  assign done                      = done_q;
  assign err                       = err_q;
  assign ram_rd                    = rd_en;
  assign ram_addr                  = addr;
  assign m_udp_hdr_valid           = hdr_valid_q;
  assign m_udp_ip_dest_ip          = ip_q;
  assign m_udp_source_port         = sport_q;
  assign m_udp_dest_port           = dport_q;
  assign m_udp_length              = length_q;
  assign m_udp_payload_axis_tvalid = tvalid_i;
  assign m_udp_payload_axis_tdata  = tvalid_i ? head_byte : 8'h00;
  assign m_udp_payload_axis_tlast  = tlast_i;
  assign m_udp_payload_axis_tuser  = 1'b0;
endmodule

// File: tb/tb_udp_payload_streamer.sv
// Directed bench for udp_payload_streamer: RAM model, beat/read monitor at negedge,
// hand-written packets checked against an expected byte queue.
module tb_udp_payload_streamer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [10:0] out_len = '0;
  logic [15:0] udp_dest_port = '0, udp_source_port = '0;
  logic [31:0] ip_dest_ip = '0;
  logic        busy, done, err, ram_rd;
  logic [9:0]  ram_addr;
  logic [15:0] ram_q = '0;
  logic        hdr_valid, hdr_ready = 1'b1;
  logic [31:0] hdr_ip;
  logic [15:0] hdr_sport, hdr_dport, hdr_length;
  logic [7:0]  tdata;
  logic        tvalid, tready = 1'b1, tlast, tuser;

  udp_payload_streamer #(.ADDR_WIDTH(10), .LEN_WIDTH(11)) dut (
    .clk(clk), .rst(rst), .start(start), .out_len(out_len),
    .udp_dest_port(udp_dest_port), .udp_source_port(udp_source_port), .ip_dest_ip(ip_dest_ip),
    .busy(busy), .done(done), .err(err), .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_q(ram_q),
    .m_udp_hdr_valid(hdr_valid), .m_udp_hdr_ready(hdr_ready),
    .m_udp_ip_dest_ip(hdr_ip), .m_udp_source_port(hdr_sport), .m_udp_dest_port(hdr_dport),
    .m_udp_length(hdr_length), .m_udp_payload_axis_tdata(tdata),
    .m_udp_payload_axis_tvalid(tvalid), .m_udp_payload_axis_tready(tready),
    .m_udp_payload_axis_tlast(tlast), .m_udp_payload_axis_tuser(tuser)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- RAM model ----------------
  logic [15:0] mem [0:1023];
  always @(posedge clk) if (ram_rd) ram_q <= mem[ram_addr];

  // ---------------- monitor ----------------
  logic [8:0] obs_data [0:4095];
  int         obs_cyc  [0:4095];
  logic [9:0] rd_log   [0:4095];
  int obs_n = 0, rd_n = 0, done_n = 0, err_n = 0, hdr_n = 0, hold_viol = 0, cyc = 0;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_beat = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (tvalid && tready) begin
      obs_data[obs_n] <= {tlast, tdata};
      obs_cyc[obs_n]  <= cyc;
      obs_n           <= obs_n + 1;
    end
    if (ram_rd) begin
      rd_log[rd_n] <= ram_addr;
      rd_n         <= rd_n + 1;
    end
    if (done) done_n <= done_n + 1;
    if (err) err_n <= err_n + 1;
    if (hdr_valid && hdr_ready) hdr_n <= hdr_n + 1;
    if (prev_stall && (!tvalid || {tlast, tdata} != prev_beat)) hold_viol <= hold_viol + 1;
    prev_stall <= tvalid && !tready;
    prev_beat  <= {tlast, tdata};
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0, n_errors = 0;
  logic [8:0] exp_q[$];
  int ob, rb, db, hb, eb, hv;
  bit rnd_ready = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] out_vec();
    return {busy, done, err, ram_rd, |ram_addr, hdr_valid, |hdr_ip, |hdr_sport, |hdr_dport,
            |hdr_length, |tdata, tvalid, tlast, tuser};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic snap();
    ob = obs_n; rb = rd_n; db = done_n; hb = hdr_n; eb = err_n; hv = hold_viol;
  endtask

  task automatic start_pkt(input logic [10:0] len, input logic [15:0] dp, input logic [15:0] sp,
                           input logic [31:0] ip);
    out_len = len; udp_dest_port = dp; udp_source_port = sp; ip_dest_ip = ip;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
      else if (rnd_ready) tready = 1'($urandom_range(0, 1));
    end
    tready = 1'b1;
    check({tag, "_done_seen"}, seen, 1);
    if (seen) check({tag, "_busy_at_done"}, busy, 0);
  endtask

  task automatic verify_pkt(input string tag, input int n);
    int bad = 0;
    int i = 0;
    logic [8:0] e, g;
    @(posedge clk); #1;
    check({tag, "_done_low"}, done, 0);
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({1'b0, mem[k][15:8]});
      exp_q.push_back({k == n - 1, mem[k][7:0]});
    end
    check({tag, "_beats"}, obs_n - ob, 2 * n);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (i < obs_n - ob) ? obs_data[ob + i] : 9'h1ff;
      check({tag, "_byte"}, g, e);
      i++;
    end
    check({tag, "_reads"}, rd_n - rb, n);
    for (int k = 0; k < rd_n - rb; k++) if (rd_log[rb + k] != 10'(k)) bad++;
    check({tag, "_rd_seq"}, bad, 0);
    check({tag, "_done_pulses"}, done_n - db, 1);
    check({tag, "_hdr_xfers"}, hdr_n - hb, 1);
    check({tag, "_hold"}, hold_viol - hv, 0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", out_vec(), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_outs", out_vec(), 0);

    // 1: single word, header fields and length 10
    mem[0] = 16'h1234;
    snap();
    start_pkt(11'd1, 16'h1234, 16'h3456, 32'hffffffff);
    check("t1_hdr_valid", hdr_valid, 1);
    check("t1_busy", busy, 1);
    check("t1_first_rd", {ram_rd, ram_addr}, {1'b1, 10'd0});
    check("t1_length", hdr_length, 16'd10);
    check("t1_dport", hdr_dport, 16'h1234);
    check("t1_sport", hdr_sport, 16'h3456);
    check("t1_ip", hdr_ip, 32'hffffffff);
    @(posedge clk); #1;
    check("t1_hdr_dropped", hdr_valid, 0);
    wait_done("t1", 20);
    verify_pkt("t1", 1);

    // 2: four words back to back, no bubbles
    for (int k = 0; k < 4; k++) mem[k] = {8'(8'hA0 + 2 * k), 8'(8'hA1 + 2 * k)};
    snap();
    start_pkt(11'd4, 16'd7, 16'd8, 32'h0a000001);
    check("t2_length", hdr_length, 16'd16);
    wait_done("t2", 40);
    check("t2_no_bubbles", obs_cyc[ob + 7] - obs_cyc[ob], 7);
    verify_pkt("t2", 4);

    // 3: sixteen words, late header ready and random backpressure
    for (int k = 0; k < 16; k++) mem[k] = {8'(8'h10 + 2 * k), 8'(8'h11 + 2 * k)};
    hdr_ready = 1'b0;
    snap();
    start_pkt(11'd16, 16'h0bad, 16'hcafe, 32'hc0a80102);
    for (int i = 0; i < 5; i++) begin
      check("t3_hdr_held", {hdr_valid, tvalid, hdr_length}, {1'b1, 1'b0, 16'd40});
      @(posedge clk); #1;
    end
    hdr_ready = 1'b1;
    rnd_ready = 1'b1;
    wait_done("t3", 400);
    rnd_ready = 1'b0;
    verify_pkt("t3", 16);

    // 4: illegal lengths are rejected with a one-cycle err
    snap();
    start_pkt(11'd0, 16'd1, 16'd2, 32'd3);
    check("t4_len0_err", {err, busy, hdr_valid}, 3'b100);
    @(posedge clk); #1;
    check("t4_len0_err_off", {err, busy, hdr_valid}, 3'b000);
    start_pkt(11'd1025, 16'd1, 16'd2, 32'd3);
    check("t4_len1025_err", {err, busy, hdr_valid}, 3'b100);
    @(posedge clk); #1;
    check("t4_len1025_err_off", {err, busy, hdr_valid}, 3'b000);
    check("t4_err_pulses", err_n - eb, 2);
    check("t4_no_hdr", hdr_n - hb, 0);

    // 5: maximum length, start while busy ignored
    for (int k = 0; k < 1024; k++) mem[k] = 16'($urandom);
    snap();
    start_pkt(11'd1024, 16'h4000, 16'h5000, 32'h01020304);
    check("t5_length", hdr_length, 16'd2056);
    repeat (100) @(posedge clk);
    #1;
    start_pkt(11'd5, 16'h1111, 16'h2222, 32'h33333333);
    check("t5_busy_start_ignored", {busy, err_n - eb}, {1'b1, 32'd0});
    check("t5_fields_kept", {hdr_length, hdr_dport}, {16'd2056, 16'h4000});
    wait_done("t5", 3000);
    check("t5_last_addr", rd_log[rd_n - 1], 10'd1023);
    verify_pkt("t5", 1024);

    // 6: async reset at byte 5 of an 8-byte packet, then a clean 4-byte packet
    for (int k = 0; k < 4; k++) mem[k] = {8'(8'hC0 + 2 * k), 8'(8'hC1 + 2 * k)};
    snap();
    start_pkt(11'd4, 16'd9, 16'd10, 32'd11);
    for (int i = 0; i < 40 && (obs_n - ob) < 5; i++) begin
      @(posedge clk); #1;
    end
    check("t6_pre_rst_tvalid", tvalid, 1);
    #1 rst = 1'b1;
    #1 check("t6_async_rst_outs", out_vec(), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("t6_partial_beats", obs_n - ob, 5);
    for (int i = 0; i < 5; i++) check("t6_partial_byte", obs_data[ob + i], {1'b0, 8'(8'hC0 + i)});
    @(posedge clk); #1;
    mem[0] = 16'hD0D1;
    mem[1] = 16'hD2D3;
    snap();
    start_pkt(11'd2, 16'd12, 16'd13, 32'd14);
    wait_done("t6", 30);
    verify_pkt("t6", 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
